// File: rtl/sha256_pkg.sv
// SHA-256 shared types, constants and round primitives.
package sha256_pkg;

  localparam int unsigned ROUNDS = 64;
  localparam int unsigned WORD_W = 32;

  typedef logic [7:0][WORD_W-1:0]  HashState;   // [7]=a/H0 ... [0]=h/H7
  typedef logic [15:0][WORD_W-1:0] Chunk;       // [15]=W0 ... [0]=W15
  typedef enum logic [1:0] {RESET, IDLE, UPDATE, DONE} ShaState;

  // Packed so that K[63] is the round-0 constant
  localparam logic [63:0][WORD_W-1:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam HashState H = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  function automatic logic [WORD_W-1:0] rightRotate32(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] rightShift(input logic [WORD_W-1:0] x, input int unsigned n);
    return x >> n;
  endfunction

  function automatic logic [WORD_W-1:0] bigSigma0(input logic [WORD_W-1:0] x);
    return rightRotate32(x, 2) ^ rightRotate32(x, 13) ^ rightRotate32(x, 22);
  endfunction

  function automatic logic [WORD_W-1:0] bigSigma1(input logic [WORD_W-1:0] x);
    return rightRotate32(x, 6) ^ rightRotate32(x, 11) ^ rightRotate32(x, 25);
  endfunction

  function automatic logic [WORD_W-1:0] smallSigma0(input logic [WORD_W-1:0] x);
    return rightRotate32(x, 7) ^ rightRotate32(x, 18) ^ rightShift(x, 3);
  endfunction

  function automatic logic [WORD_W-1:0] smallSigma1(input logic [WORD_W-1:0] x);
    return rightRotate32(x, 17) ^ rightRotate32(x, 19) ^ rightShift(x, 10);
  endfunction

  function automatic logic [WORD_W-1:0] ch(input logic [WORD_W-1:0] e, input logic [WORD_W-1:0] f,
                                           input logic [WORD_W-1:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [WORD_W-1:0] maj(input logic [WORD_W-1:0] a, input logic [WORD_W-1:0] b,
                                            input logic [WORD_W-1:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic HashState shaRound(input HashState s, input logic [WORD_W-1:0] k,
                                        input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] t1, t2;
    t1 = s[0] + bigSigma1(s[3]) + ch(s[3], s[2], s[1]) + k + w;
    t2 = bigSigma0(s[7]) + maj(s[7], s[6], s[5]);
    return {t1 + t2, s[7], s[6], s[5], s[4] + t1, s[3], s[2], s[1]};
  endfunction

endpackage

// File: rtl/sha256_compress_core_if.sv
// Chunk-in / digest-out handshake bundle of the compression core.
interface sha256_compress_core_if;
  import sha256_pkg::*;

  logic     chunk_valid;
  logic     chunk_ready;
  Chunk     chunk_data;
  logic     chunk_first;
  logic     digest_valid;
  logic     digest_ready;
  HashState digest;
  logic     busy;

  modport master (output chunk_valid, chunk_data, chunk_first, digest_ready,
                  input  chunk_ready, digest_valid, digest, busy);
  modport slave  (input  chunk_valid, chunk_data, chunk_first, digest_ready,
                  output chunk_ready, digest_valid, digest, busy);
endinterface

// File: rtl/sha256_msg_schedule.sv
// 16-word sliding message-schedule window; yields ROUNDS_PER_CYCLE W words per cycle.
module sha256_msg_schedule
  import sha256_pkg::*;
#(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   i_load,
  input  logic                                   i_shift,
  input  Chunk                                   i_chunk,
  output logic [ROUNDS_PER_CYCLE-1:0][WORD_W-1:0] o_w_c
);

  Chunk r_win;
  Chunk w_win_nxt;

  // ext[j] = W[t+j]; words beyond the window are expanded on the fly
  always_comb begin
    logic [WORD_W-1:0] ext [16+ROUNDS_PER_CYCLE];
    for (int unsigned j = 0; j < 16; j++) ext[j] = r_win[15-j];
    for (int unsigned i = 0; i < ROUNDS_PER_CYCLE; i++) begin
      ext[16+i] = smallSigma1(ext[14+i]) + ext[9+i] + smallSigma0(ext[1+i]) + ext[i];
    end
    for (int unsigned i = 0; i < ROUNDS_PER_CYCLE; i++) o_w_c[i] = ext[i];
    for (int unsigned j = 0; j < 16; j++) w_win_nxt[15-j] = ext[j+ROUNDS_PER_CYCLE];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_win <= '0;
    else if (i_load)  r_win <= i_chunk;
    else if (i_shift) r_win <= w_win_nxt;
  end

endmodule

// File: rtl/sha256_compress_core.sv
// Iterative SHA-256 compression engine, ROUNDS_PER_CYCLE rounds per clock, chained HashState.
module sha256_compress_core
  import sha256_pkg::*;
#(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input logic                   clk,
  input logic                   rst,
  sha256_compress_core_if.slave bus
);

  localparam int unsigned CNT_W      = 7;
  localparam int unsigned LAST_ROUND = ROUNDS - ROUNDS_PER_CYCLE;

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
        ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 8)) begin : g_bad_rounds
    $error("sha256_compress_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  ShaState                               r_state, w_state_nxt;
  HashState                              r_chain, r_vars, w_vars_nxt, w_feedfwd;
  logic [CNT_W-1:0]                      r_round;
  logic                                  r_chunk_ready, r_digest_valid, r_busy;
  logic                                  w_accept, w_last;
  logic [ROUNDS_PER_CYCLE-1:0][WORD_W-1:0] w_w;

  assign w_accept = (r_state == IDLE) && bus.chunk_valid;
  assign w_last   = (r_state == UPDATE) && (r_round == CNT_W'(LAST_ROUND));

  sha256_msg_schedule #(.ROUNDS_PER_CYCLE(ROUNDS_PER_CYCLE)) u_sched (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_accept),
    .i_shift (r_state == UPDATE),
    .i_chunk (bus.chunk_data),
    .o_w_c   (w_w)
  );

  // Next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RESET:   w_state_nxt = IDLE;
      IDLE:    if (w_accept) w_state_nxt = UPDATE;
      UPDATE:  if (w_last) w_state_nxt = DONE;
      DONE:    if (bus.digest_ready) w_state_nxt = IDLE;
      default: w_state_nxt = RESET;
    endcase
  end

  // Handshake flags are registered off the next state so they track the FSM exactly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= RESET;
      r_chunk_ready  <= 1'b0;
      r_digest_valid <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_chunk_ready  <= (w_state_nxt == IDLE);
      r_digest_valid <= (w_state_nxt == DONE);
      r_busy         <= (w_state_nxt == UPDATE) || (w_state_nxt == DONE);
    end
  end

  // Combinationally chained rounds for this cycle, plus the feed-forward sum
  always_comb begin
    HashState v;
    v = r_vars;
    for (int unsigned i = 0; i < ROUNDS_PER_CYCLE; i++) begin
      v = shaRound(v, K[6'(ROUNDS - 1) - 6'(r_round) - 6'(i)], w_w[i]);
    end
    w_vars_nxt = v;
    for (int unsigned i = 0; i < 8; i++) w_feedfwd[i] = r_chain[i] + v[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chain <= H;
      r_vars  <= '0;
      r_round <= '0;
    end else if (w_accept) begin
      r_vars  <= bus.chunk_first ? H : r_chain;
      r_round <= '0;
      if (bus.chunk_first) r_chain <= H;
    end else if (r_state == UPDATE) begin
      r_vars  <= w_vars_nxt;
      r_round <= r_round + CNT_W'(ROUNDS_PER_CYCLE);
      if (w_last) r_chain <= w_feedfwd;
    end
  end

  assign bus.chunk_ready  = r_chunk_ready;
  assign bus.digest_valid = r_digest_valid;
  assign bus.digest       = r_chain;
  assign bus.busy         = r_busy;

endmodule

// File: tb/tb_sha256_compress_core.sv
// Directed bench for sha256_compress_core at ROUNDS_PER_CYCLE = 1, 2, 4, 8 against a plain SHA-256 model.
module tb_sha256_compress_core;
  import sha256_pkg::*;

  localparam int NDUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic     tb_cv [NDUT];
  logic     tb_cf [NDUT];
  logic     tb_dr [NDUT];
  Chunk     tb_cd [NDUT];
  logic     tb_crdy [NDUT];
  logic     tb_dv [NDUT];
  logic     tb_busy [NDUT];
  HashState tb_dig [NDUT];
  HashState exp_dig [NDUT];

  int n_cmp  = 0;
  int n_fail = 0;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    sha256_compress_core_if u_if ();
    assign u_if.chunk_valid  = tb_cv[g];
    assign u_if.chunk_first  = tb_cf[g];
    assign u_if.chunk_data   = tb_cd[g];
    assign u_if.digest_ready = tb_dr[g];
    assign tb_crdy[g] = u_if.chunk_ready;
    assign tb_dv[g]   = u_if.digest_valid;
    assign tb_busy[g] = u_if.busy;
    assign tb_dig[g]  = u_if.digest;
    sha256_compress_core #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
    );
  end

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [255:0] H_TB    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] LIT_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] LIT_EMP = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] LIT_448 = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook compression: full 64-word schedule, a..h as an array
  function automatic HashState model(input HashState hin, input Chunk c);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] s0, s1, t1, t2;
    HashState r;
    for (int t = 0; t < 16; t++) w[t] = c[15-t];
    for (int t = 16; t < 64; t++) begin
      s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int i = 0; i < 8; i++) v[i] = hin[7-i];
    for (int t = 0; t < 64; t++) begin
      s1 = rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25);
      t1 = v[7] + s1 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      s0 = rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22);
      t2 = s0 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[7-i] = hin[7-i] + v[i];
    return r;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every cycle a digest is presented it must equal the model and exclude chunk_ready
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < NDUT; d++) begin
        if (tb_dv[d]) begin
          check($sformatf("digest_r%0d", 1 << d), tb_dig[d], exp_dig[d]);
          check($sformatf("excl_ready_r%0d", 1 << d), 256'(tb_crdy[d]), 256'(0));
          check($sformatf("busy_done_r%0d", 1 << d), 256'(tb_busy[d]), 256'(1));
        end
      end
    end
  end

  task automatic start(input int d, input Chunk c, input logic first);
    int n;
    n = 0;
    tb_cd[d] = c;
    tb_cf[d] = first;
    tb_cv[d] = 1'b1;
    while (!tb_crdy[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("ready_wait_r%0d", 1 << d), 256'(tb_crdy[d]), 256'(1));
    @(negedge clk);
    tb_cv[d] = 1'b0;
  endtask

  task automatic wait_digest(input int d, output int lat);
    int n;
    n = 0;
    while (!tb_dv[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    lat = n + 1;
  endtask

  task automatic release_digest(input int d);
    tb_dr[d] = 1'b1;
    @(negedge clk);
    tb_dr[d] = 1'b0;
    check($sformatf("idle_ready_r%0d", 1 << d), 256'(tb_crdy[d]), 256'(1));
    check($sformatf("idle_valid_r%0d", 1 << d), 256'(tb_dv[d]), 256'(0));
  endtask

  task automatic run(input int d, input Chunk c, input logic first, input HashState exp, input string name);
    int lat;
    exp_dig[d] = exp;
    start(d, c, first);
    wait_digest(d, lat);
    check($sformatf("latency_%s_r%0d", name, 1 << d), 256'(lat), 256'(64 / (1 << d) + 1));
    check($sformatf("lit_%s_r%0d", name, 1 << d), tb_dig[d], exp);
    release_digest(d);
  endtask

  initial begin
    Chunk abc, emp, m1, m2;
    HashState h1;
    int lat;
    abc = {32'h61626380, {14{32'h0}}, 32'h00000018};
    emp = {32'h80000000, {15{32'h0}}};
    m1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
           32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
           32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    m2  = {{15{32'h0}}, 32'h000001c0};
    for (int d = 0; d < NDUT; d++) begin
      tb_cv[d] = 1'b0; tb_cf[d] = 1'b0; tb_dr[d] = 1'b0; tb_cd[d] = '0; exp_dig[d] = H_TB;
    end

    check("model_abc", model(H_TB, abc), LIT_ABC);
    check("model_empty", model(H_TB, emp), LIT_EMP);
    h1 = model(H_TB, m1);
    check("model_448", model(h1, m2), LIT_448);

    repeat (3) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("rst_ready_r%0d", 1 << d), 256'(tb_crdy[d]), 256'(0));
      check($sformatf("rst_valid_r%0d", 1 << d), 256'(tb_dv[d]), 256'(0));
      check($sformatf("rst_busy_r%0d", 1 << d), 256'(tb_busy[d]), 256'(0));
      check($sformatf("rst_digest_r%0d", 1 << d), tb_dig[d], H_TB);
    end
    rst = 1'b0;
    #1 check("reset_state_ready", 256'(tb_crdy[0]), 256'(0));
    @(negedge clk);
    check("idle_after_reset", 256'(tb_crdy[0]), 256'(1));

    for (int d = 0; d < NDUT; d++) begin
      run(d, abc, 1'b1, LIT_ABC, "abc");
      run(d, emp, 1'b1, LIT_EMP, "empty");
      run(d, m1, 1'b1, h1, "blk1");
      run(d, m2, 1'b0, LIT_448, "blk2");

      // Backpressure with a spurious chunk offered while DONE
      exp_dig[d] = LIT_ABC;
      start(d, abc, 1'b1);
      wait_digest(d, lat);
      tb_cd[d] = emp;
      tb_cv[d] = 1'b1;
      repeat (10) begin
        @(negedge clk);
        check($sformatf("bp_valid_r%0d", 1 << d), 256'(tb_dv[d]), 256'(1));
        check($sformatf("bp_digest_r%0d", 1 << d), tb_dig[d], LIT_ABC);
        check($sformatf("bp_ready_r%0d", 1 << d), 256'(tb_crdy[d]), 256'(0));
      end
      tb_cv[d] = 1'b0;
      release_digest(d);
      check($sformatf("bp_not_taken_r%0d", 1 << d), 256'(tb_busy[d]), 256'(0));

      // Abort mid-UPDATE, then chunk_first=0 must still chain from H
      start(d, abc, 1'b1);
      repeat (30 / (1 << d)) @(negedge clk);
      check($sformatf("mid_busy_r%0d", 1 << d), 256'(tb_busy[d]), 256'(1));
      rst = 1'b1;
      #1;
      check($sformatf("abort_busy_r%0d", 1 << d), 256'(tb_busy[d]), 256'(0));
      check($sformatf("abort_valid_r%0d", 1 << d), 256'(tb_dv[d]), 256'(0));
      check($sformatf("abort_ready_r%0d", 1 << d), 256'(tb_crdy[d]), 256'(0));
      check($sformatf("abort_digest_r%0d", 1 << d), tb_dig[d], H_TB);
      @(negedge clk);
      rst = 1'b0;
      run(d, abc, 1'b0, LIT_ABC, "rerun");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
